// File: rtl/watchdog_pkg.sv
// rtl/watchdog_pkg.sv - shared state encoding and default constants for the watchdog/RF shutdown path
package watchdog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RAMP  = 2'd2,
        ST_FAULT = 2'd3
    } rf_state_e;

    localparam int GAIN_W_DEF     = 16;
    localparam int STEP_DEF       = 256;
    localparam int RAMP_DIV_DEF   = 1000;
    localparam int WARN_SHIFT_DEF = 1;

endpackage

// File: rtl/rf_safe_shutdown.sv
// rtl/rf_safe_shutdown.sv - watchdog-driven carrier gain limiter with graceful ramp-down and latched fault
module rf_safe_shutdown
    import watchdog_pkg::*;
#(
    parameter int GAIN_W     = GAIN_W_DEF,
    parameter int STEP       = STEP_DEF,
    parameter int RAMP_DIV   = RAMP_DIV_DEF,
    parameter int WARN_SHIFT = WARN_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wd_triggered,
    input  logic              wd_warning,
    input  logic              rf_enable_req,
    input  logic [GAIN_W-1:0] gain_in,
    input  logic              clear_fault,
    output logic [GAIN_W-1:0] gain_out,
    output logic              rf_enable_out,
    output logic              fault_latched,
    output logic [1:0]        state_o
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [GAIN_W-1:0] STEP_G   = GAIN_W'(STEP);

    rf_state_e         state_q;
    logic [GAIN_W-1:0] gain_q;
    logic              rf_en_q;
    logic              fault_q;
    logic [DIV_W-1:0]  div_q;

    logic [GAIN_W-1:0] gain_run_d;
    logic [GAIN_W-1:0] gain_dec_d;
    logic              tick_d;
    logic              fault_ramp_d;

    always_comb begin
        gain_run_d   = wd_warning ? (gain_in >> WARN_SHIFT) : gain_in;
        // Saturating step: never wraps below zero.
        gain_dec_d   = (gain_q > STEP_G) ? (gain_q - STEP_G) : '0;
        tick_d       = (div_q == DIV_LAST);
        fault_ramp_d = fault_q | wd_triggered;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            gain_q  <= '0;
            rf_en_q <= 1'b0;
            fault_q <= 1'b0;
            div_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gain_q  <= '0;
                    rf_en_q <= 1'b0;
                    if (rf_enable_req && !wd_triggered) begin
                        state_q <= ST_RUN;
                        rf_en_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    rf_en_q <= 1'b1;
                    div_q   <= '0;
                    if (wd_triggered) begin
                        state_q <= ST_RAMP;
                        fault_q <= 1'b1;
                    end else if (!rf_enable_req) begin
                        state_q <= ST_RAMP;
                    end else begin
                        gain_q <= gain_run_d;
                    end
                end
                ST_RAMP: begin
                    fault_q <= fault_ramp_d;
                    // Exit is decided on the registered gain, so a zero entry costs one cycle.
                    if (gain_q == '0) begin
                        state_q <= fault_ramp_d ? ST_FAULT : ST_IDLE;
                        rf_en_q <= 1'b0;
                        div_q   <= '0;
                    end else if (tick_d) begin
                        div_q  <= '0;
                        gain_q <= gain_dec_d;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    gain_q  <= '0;
                    rf_en_q <= 1'b0;
                    fault_q <= 1'b1;
                    if (clear_fault && !wd_triggered) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gain_out      = gain_q;
    assign rf_enable_out = rf_en_q;
    assign fault_latched = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_rf_safe_shutdown.sv
// tb/tb_rf_safe_shutdown.sv - directed self-checking bench for rf_safe_shutdown
module tb_rf_safe_shutdown;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wd_triggered;
    logic        wd_warning;
    logic        rf_enable_req;
    logic [15:0] gain_in;
    logic        clear_fault;
    logic [15:0] gain_out;
    logic        rf_enable_out;
    logic        fault_latched;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_RAMP = 2'd2, S_FAULT = 2'd3;

    rf_safe_shutdown #(
        .GAIN_W(16), .STEP(256), .RAMP_DIV(4), .WARN_SHIFT(1)
    ) dut (
        .clk(clk), .rstn(rstn), .wd_triggered(wd_triggered), .wd_warning(wd_warning),
        .rf_enable_req(rf_enable_req), .gain_in(gain_in), .clear_fault(clear_fault),
        .gain_out(gain_out), .rf_enable_out(rf_enable_out), .fault_latched(fault_latched),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [15:0] g,
                             input logic en, input logic flt);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".gain"}, 32'(gain_out), 32'(g));
        check({tag, ".en"}, 32'(rf_enable_out), 32'(en));
        check({tag, ".fault"}, 32'(fault_latched), 32'(flt));
    endtask

    initial begin
        rstn = 1'b0; wd_triggered = 1'b0; wd_warning = 1'b0;
        rf_enable_req = 1'b0; gain_in = 16'h0000; clear_fault = 1'b0;
        step(2);
        check_all("reset", S_IDLE, 16'h0000, 1'b0, 1'b0);

        rstn = 1'b1; rf_enable_req = 1'b1; gain_in = 16'h0400;
        step(1);
        check_all("run_entry", S_RUN, 16'h0000, 1'b1, 1'b0);
        step(1);
        check_all("run_track", S_RUN, 16'h0400, 1'b1, 1'b0);

        wd_warning = 1'b1;
        step(1);
        check("warn_half", 32'(gain_out), 32'h0200);
        wd_warning = 1'b0;
        step(1);
        check("warn_off", 32'(gain_out), 32'h0400);

        wd_triggered = 1'b1;
        step(1);
        wd_triggered = 1'b0;
        check_all("trig_entry", S_RAMP, 16'h0400, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(3);
            check($sformatf("ramp_hold%0d", k), 32'(gain_out), 32'(16'h0400 - (k - 1) * 16'h0100));
            step(1);
            check($sformatf("ramp_step%0d", k), 32'(gain_out), 32'(16'h0400 - k * 16'h0100));
        end
        check("ramp_zero_state", 32'(state_o), 32'(S_RAMP));
        check("ramp_zero_en", 32'(rf_enable_out), 32'h1);
        step(1);
        check_all("fault", S_FAULT, 16'h0000, 1'b0, 1'b1);

        clear_fault = 1'b1; wd_triggered = 1'b1;
        step(1);
        check_all("clr_blocked", S_FAULT, 16'h0000, 1'b0, 1'b1);
        wd_triggered = 1'b0;
        step(1);
        clear_fault = 1'b0;
        check_all("clr_ok", S_IDLE, 16'h0000, 1'b0, 1'b0);
        step(1);
        check("rerun", 32'(state_o), 32'(S_RUN));
        step(1);
        check("rerun_gain", 32'(gain_out), 32'h0400);

        gain_in = 16'h0150;
        step(1);
        check("g150", 32'(gain_out), 32'h0150);
        rf_enable_req = 1'b0;
        step(1);
        check_all("grace_entry", S_RAMP, 16'h0150, 1'b1, 1'b0);
        step(4);
        check("grace_50", 32'(gain_out), 32'h0050);
        step(4);
        check("grace_sat", 32'(gain_out), 32'h0000);
        step(1);
        check_all("grace_idle", S_IDLE, 16'h0000, 1'b0, 1'b0);

        rf_enable_req = 1'b1;
        step(2);
        check("g150b", 32'(gain_out), 32'h0150);
        rf_enable_req = 1'b0;
        step(1);
        check("grace2_entry", 32'(state_o), 32'(S_RAMP));
        step(2);
        wd_triggered = 1'b1;
        step(1);
        wd_triggered = 1'b0;
        check_all("mid_trig", S_RAMP, 16'h0150, 1'b1, 1'b1);
        step(1);
        check("mid_50", 32'(gain_out), 32'h0050);
        step(4);
        check("mid_zero", 32'(gain_out), 32'h0000);
        step(1);
        check_all("mid_fault", S_FAULT, 16'h0000, 1'b0, 1'b1);

        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check("clr2", 32'(state_o), 32'(S_IDLE));
        rf_enable_req = 1'b1; wd_triggered = 1'b1; gain_in = 16'h0400;
        step(1);
        check("idle_trig_hold", 32'(state_o), 32'(S_IDLE));
        wd_triggered = 1'b0;
        step(2);
        check("run3_gain", 32'(gain_out), 32'h0400);
        rf_enable_req = 1'b0;
        step(1);
        step(8);
        check("pre_rst_gain", 32'(gain_out), 32'h0200);
        rstn = 1'b0;
        step(1);
        check_all("rst_mid_ramp", S_IDLE, 16'h0000, 1'b0, 1'b0);

        rstn = 1'b1; rf_enable_req = 1'b1; gain_in = 16'h0000;
        step(2);
        check("zero_run", 32'(state_o), 32'(S_RUN));
        rf_enable_req = 1'b0;
        step(1);
        check("zero_ramp", 32'(state_o), 32'(S_RAMP));
        step(1);
        check_all("zero_exit", S_IDLE, 16'h0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
